// File: rtl/multiport_regfile.sv
// multiport_regfile: register file with NUM_RD combinational read ports, one
// synchronous write port with optional same-cycle forwarding, an optional
// hardwired-zero register 0, and a per-register pending scoreboard so decode
// can see RAW hazards against in-flight producers.

// Per-read-port lane: range/zero masking, write forwarding and busy lookup.
module multiport_regfile_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            pend,
  input  logic                        wr_ok,
  input  logic [ADDR_W-1:0]           wa,
  input  logic [WIDTH-1:0]            wd,
  input  logic [ADDR_W-1:0]           radr,
  output logic [WIDTH-1:0]            rdata,
  output logic                        busy
);
  logic readable;
  logic hit;

  // Zero register and out-of-range addresses read as 0 and are never busy.
  assign readable = (32'(radr) < 32'(DEPTH)) && !((ZERO_REG != 0) && (radr == '0));
  // wr_ok already implies a writable WA, so a hit is always on a readable reg.
  assign hit      = (BYPASS != 0) && wr_ok && (wa == radr);

  // Pick forwarded, stored or zero data; a forwarded value clears busy.
  always_comb begin
    rdata = '0;
    busy  = 1'b0;
    if (readable) begin
      if (hit) begin
        rdata = wd;
      end else begin
        rdata = mem[radr];
        busy  = pend[radr];
      end
    end
  end
endmodule

module multiport_regfile #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [ADDR_W-1:0]        WA,
  input  logic [WIDTH-1:0]         WD,
  input  logic [NUM_RD*ADDR_W-1:0] RADR,
  output logic [NUM_RD*WIDTH-1:0]  RDATA,
  output logic [NUM_RD-1:0]        BUSY,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_RD
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            pend;
  logic [DEPTH-1:0]            pend_nxt;
  logic                        wr_ok;
  logic                        iss_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = EN && writable(WA);
  assign iss_ok = ISSUE_EN && writable(ISSUE_RD);

  // Scoreboard update: retire first, then issue, so a same-register issue wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok)  pend_nxt[WA]       = 1'b0;
    if (iss_ok) pend_nxt[ISSUE_RD] = 1'b1;
  end

  // Storage and scoreboard state; reset discards any same-cycle write/issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem  <= '0;
      pend <= '0;
    end else begin
      if (wr_ok) mem[WA] <= WD;
      pend <= pend_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    multiport_regfile_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .mem  (mem),
      .pend (pend),
      .wr_ok(wr_ok),
      .wa   (WA),
      .wd   (WD),
      .radr (RADR[g*ADDR_W +: ADDR_W]),
      .rdata(RDATA[g*WIDTH +: WIDTH]),
      .busy (BUSY[g])
    );
  end
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: default config (a), no-bypass DEPTH=24 config (b) sharing
// a's inputs, and a wide 4-port DEPTH=16 config (c).
module tb_multiport_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus for a and b (both ADDR_W=5, WIDTH=32, NUM_RD=2)
  logic        en, issue_en;
  logic [4:0]  wa, issue_rd;
  logic [31:0] wd;
  logic [9:0]  radr;
  logic [63:0] a_rdata, b_rdata;
  logic [1:0]  a_busy, b_busy;

  // c: WIDTH=64, DEPTH=16, NUM_RD=4
  logic         c_en, c_issue_en;
  logic [3:0]   c_wa, c_issue_rd;
  logic [63:0]  c_wd;
  logic [15:0]  c_radr;
  logic [255:0] c_rdata;
  logic [3:0]   c_busy;

  int checks = 0;
  int failures = 0;

  multiport_regfile u_a (
    .CLK(clk), .RST(rst), .EN(en), .WA(wa), .WD(wd), .RADR(radr),
    .RDATA(a_rdata), .BUSY(a_busy), .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd)
  );

  multiport_regfile #(.DEPTH(24), .BYPASS(0)) u_b (
    .CLK(clk), .RST(rst), .EN(en), .WA(wa), .WD(wd), .RADR(radr),
    .RDATA(b_rdata), .BUSY(b_busy), .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd)
  );

  multiport_regfile #(.WIDTH(64), .DEPTH(16), .NUM_RD(4)) u_c (
    .CLK(clk), .RST(rst), .EN(c_en), .WA(c_wa), .WD(c_wd), .RADR(c_radr),
    .RDATA(c_rdata), .BUSY(c_busy), .ISSUE_EN(c_issue_en), .ISSUE_RD(c_issue_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 0; issue_en = 0; wa = 0; issue_rd = 0; wd = 0; radr = 0;
    c_en = 0; c_issue_en = 0; c_wa = 0; c_issue_rd = 0; c_wd = 0; c_radr = 0;
    step();
    rst = 1'b0;

    // reset state
    radr = {5'd1, 5'd0}; #1;
    chk("rst_a_rd01", a_rdata, 64'd0);
    chk("rst_a_busy", {62'd0, a_busy}, 64'd0);
    radr = {5'd31, 5'd0}; #1;
    chk("rst_a_rd31", a_rdata[63:32], 64'd0);
    chk("rst_b_busy", {62'd0, b_busy}, 64'd0);

    // write to reg0 is ignored
    en = 1; wa = 5'd0; wd = 32'h12; radr = {5'd0, 5'd0};
    step(); en = 0; #1;
    chk("zero_a", a_rdata[31:0], 64'd0);
    chk("zero_b", b_rdata[31:0], 64'd0);

    // write 1, then EN=0 attempt on 2
    en = 1; wa = 5'd1; wd = 32'h12; step();
    en = 0; wa = 5'd2; wd = 32'hFF; step();
    radr = {5'd2, 5'd1}; #1;
    chk("wr_a_r1", a_rdata[31:0], 64'h12);
    chk("wr_a_r2", a_rdata[63:32], 64'd0);
    chk("wr_b_r1", b_rdata[31:0], 64'h12);

    // reg31: valid in a, out of range in b (DEPTH=24)
    en = 1; wa = 5'd31; wd = 32'hDEADBEEF; step(); en = 0;
    radr = {5'd31, 5'd1}; #1;
    chk("wr_a_r31", a_rdata[63:32], 64'hDEADBEEF);
    chk("oor_b_r31", b_rdata[63:32], 64'd0);

    // bypass vs no bypass
    en = 1; wa = 5'd5; wd = 32'hA5; radr = {5'd1, 5'd5}; #1;
    chk("byp_a_same", a_rdata[31:0], 64'hA5);
    chk("byp_b_same", b_rdata[31:0], 64'd0);
    step(); en = 0; #1;
    chk("byp_a_after", a_rdata[31:0], 64'hA5);
    chk("byp_b_after", b_rdata[31:0], 64'hA5);

    // scoreboard set
    issue_en = 1; issue_rd = 5'd7; step(); issue_en = 0;
    radr = {5'd0, 5'd7}; #1;
    chk("sb_a_set", {62'd0, a_busy}, 64'b01);
    chk("sb_b_set", {62'd0, b_busy}, 64'b01);
    // writeback: forwarded in a clears busy same cycle, b stays busy
    en = 1; wa = 5'd7; wd = 32'h77; #1;
    chk("sb_a_wbcyc", {62'd0, a_busy}, 64'b00);
    chk("sb_b_wbcyc", {62'd0, b_busy}, 64'b01);
    step(); en = 0; #1;
    chk("sb_a_clr", {62'd0, a_busy}, 64'b00);
    chk("sb_b_clr", {62'd0, b_busy}, 64'b00);
    // same-register issue and writeback: set wins
    issue_en = 1; issue_rd = 5'd7; en = 1; wa = 5'd7; wd = 32'h78;
    step(); issue_en = 0; en = 0; #1;
    chk("sb_a_setwins", {62'd0, a_busy}, 64'b01);
    chk("sb_a_setwins_d", a_rdata[31:0], 64'h78);
    chk("sb_b_setwins", {62'd0, b_busy}, 64'b01);
    // different registers: issue 8, retire 7
    issue_en = 1; issue_rd = 5'd8; en = 1; wa = 5'd7; wd = 32'h79;
    step(); issue_en = 0; en = 0;
    radr = {5'd8, 5'd7}; #1;
    chk("sb_a_both", {62'd0, a_busy}, 64'b10);

    // reset mid-operation
    issue_en = 1; issue_rd = 5'd3; en = 1; wa = 5'd3; wd = 32'h55;
    step(); issue_en = 0; en = 0;
    radr = {5'd0, 5'd3}; #1;
    chk("mid_a_pre_d", a_rdata[31:0], 64'h55);
    chk("mid_a_pre_b", {62'd0, a_busy}, 64'b01);
    rst = 1; en = 1; wa = 5'd4; wd = 32'h99; issue_en = 1; issue_rd = 5'd6;
    step(); rst = 0; en = 0; issue_en = 0;
    radr = {5'd4, 5'd3}; #1;
    chk("mid_a_d", a_rdata, 64'd0);
    chk("mid_a_busy", {62'd0, a_busy}, 64'd0);
    radr = {5'd6, 5'd8}; #1;
    chk("mid_a_busy68", {62'd0, a_busy}, 64'd0);
    chk("mid_b_busy68", {62'd0, b_busy}, 64'd0);

    // wide 4-port config
    c_en = 1;
    c_wa = 4'd3;  c_wd = 64'h1111_2222_3333_4444; step();
    c_wa = 4'd6;  c_wd = 64'hAAAA_5555_AAAA_5555; step();
    c_wa = 4'd9;  c_wd = 64'h0123_4567_89AB_CDEF; step();
    c_wa = 4'd15; c_wd = 64'hFFFF_FFFF_0000_0001; step();
    c_en = 0;
    c_radr = {4'd15, 4'd9, 4'd6, 4'd3}; #1;
    chk("c_p0", c_rdata[0*64 +: 64], 64'h1111_2222_3333_4444);
    chk("c_p1", c_rdata[1*64 +: 64], 64'hAAAA_5555_AAAA_5555);
    chk("c_p2", c_rdata[2*64 +: 64], 64'h0123_4567_89AB_CDEF);
    chk("c_p3_r15", c_rdata[3*64 +: 64], 64'hFFFF_FFFF_0000_0001);
    c_issue_en = 1; c_issue_rd = 4'd9; step(); c_issue_en = 0; #1;
    chk("c_busy", {60'd0, c_busy}, 64'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
